// File: rtl/result_collector_if.sv
// Accumulator-capture and result-stream signals of result_collector.
// master: array/writer side, slave: the collector.
interface result_collector_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       acc_valid_i;
  logic [N*ACC_W-1:0] acc_data_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [OUT_W-1:0]   out_data_o;
  logic [IdxW-1:0]    out_row_o;
  logic [IdxW-1:0]    out_col_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  modport master (
    output acc_valid_i, acc_data_i, out_ready_i,
    input  out_valid_o, out_data_o, out_row_o, out_col_o, busy_o, done_o, err_o
  );

  modport slave (
    input  acc_valid_i, acc_data_i, out_ready_i,
    output out_valid_o, out_data_o, out_row_o, out_col_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/result_collector.sv
// Buffers an N x N accumulator matrix from per-row strobes, then drains it row-major.
// Optional macro RESULT_COLLECTOR_SAT_EN: saturate instead of truncate on width conversion.
module result_collector #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               start_i,
  result_collector_if.slave bus
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ColW = $clog2(N + 1);
  localparam int unsigned CntW = $clog2(N * N + 1);
  localparam int unsigned RdW  = (N > 1) ? $clog2(N * N) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ColW-1:0]  col_q [N];
  logic [ColW-1:0]  col_d [N];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  inc;
  logic [RdW-1:0]   rd_q, rd_d;
  logic             err_q, err_d;
  logic [N-1:0]     we;
  logic [ACC_W-1:0] mem_q [N][N];
  logic [IdxW-1:0]  rd_row, rd_col;
  logic [ACC_W-1:0] rd_word;
  logic [OUT_W-1:0] conv_word;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    we      = '0;
    inc     = '0;
    if (start_i) begin
      // Restart wins over everything, including strobes in the same cycle.
      state_d = StCollect;
      for (int k = 0; k < N; k++) col_d[k] = '0;
      cnt_d = '0;
      rd_d  = '0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        StCollect: begin
          for (int k = 0; k < N; k++) begin
            if (bus.acc_valid_i[k]) begin
              if (col_q[k] == ColW'(N)) begin
                err_d = 1'b1;
              end else begin
                we[k]    = 1'b1;
                col_d[k] = col_q[k] + ColW'(1);
                inc      = inc + CntW'(1);
              end
            end
          end
          cnt_d = cnt_q + inc;
          if (cnt_d == CntW'(N * N)) state_d = StDrain;
        end
        StDrain: begin
          if (|bus.acc_valid_i) err_d = 1'b1;
          if (bus.out_ready_i) begin
            rd_d = rd_q + RdW'(1);
            if (rd_q == RdW'(N * N - 1)) state_d = StDone;
          end
        end
        default: begin
          if (|bus.acc_valid_i) err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      for (int k = 0; k < N; k++) col_q[k] <= '0;
      cnt_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Buffer contents need no reset; counters decide what is valid.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (we[k]) mem_q[k][IdxW'(col_q[k])] <= bus.acc_data_i[k*ACC_W +: ACC_W];
    end
  end

  assign rd_row  = IdxW'(rd_q / RdW'(N));
  assign rd_col  = IdxW'(rd_q % RdW'(N));
  assign rd_word = mem_q[rd_row][rd_col];

`ifdef RESULT_COLLECTOR_SAT_EN
  localparam logic [ACC_W-1:0] SatMax = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] SatMin = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  always_comb begin
    conv_word = rd_word[OUT_W-1:0];
    if ($signed(rd_word) > $signed(SatMax)) begin
      conv_word = SatMax[OUT_W-1:0];
    end else if ($signed(rd_word) < $signed(SatMin)) begin
      conv_word = SatMin[OUT_W-1:0];
    end
  end
`else
  assign conv_word = rd_word[OUT_W-1:0];
  if (OUT_W < ACC_W) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^rd_word[ACC_W-1:OUT_W];
  end
`endif

  assign bus.out_valid_o = (state_q == StDrain);
  assign bus.out_data_o  = conv_word;
  assign bus.out_row_o   = rd_row;
  assign bus.out_col_o   = rd_col;
  assign bus.busy_o      = (state_q == StCollect) || (state_q == StDrain);
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: fill/drain, skew, backpressure, errors,
// restart, asynchronous reset and width conversion.
module tb_result_collector;
  localparam int unsigned N     = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned WORDS = N * N;

  typedef struct packed {
    logic [31:0] acc;
    logic [15:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [ACC_W-1:0] exp_mem [WORDS];
  logic [OUT_W-1:0] got [WORDS];
  vec_t             tbl [4];

  result_collector_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  result_collector #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] v);
`ifdef RESULT_COLLECTOR_SAT_EN
    if ($signed(v) > 32'sd32767) return 16'h7fff;
    if ($signed(v) < -32'sd32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_pattern(input int off);
    for (int w = 0; w < WORDS; w++) exp_mem[w] = 32'(off + 16 * (w / N) + (w % N));
  endtask

  // Drives exp_mem into the lanes, aligned or skewed by lane index.
  task automatic fill(input bit skew);
    int last;
    last = skew ? (2 * N - 2) : (N - 1);
    for (int cyc = 0; cyc <= last; cyc++) begin
      bus.acc_valid_i = '0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = skew ? (cyc - k) : cyc;
        if (c >= 0 && c < N) begin
          bus.acc_valid_i[k]               = 1'b1;
          bus.acc_data_i[k*ACC_W +: ACC_W] = exp_mem[k*N+c];
        end
      end
      if (cyc == last) chk("no_drain_before_last_capture", 32'(bus.out_valid_o), 0);
      tick();
    end
    bus.acc_valid_i = '0;
    chk("drain_after_last_capture", 32'(bus.out_valid_o), 1);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
  task automatic drain(input int mode, input int stop_at);
    int          words;
    int          cyc;
    bit          stalled;
    logic [31:0] prev;
    logic [31:0] cur;
    words   = 0;
    cyc     = 0;
    stalled = 1'b0;
    prev    = '0;
    while (words < stop_at && cyc < 400) begin
      bus.out_ready_i = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (!bus.out_valid_o) begin
        chk("valid_during_drain", 32'(bus.out_valid_o), 1);
        break;
      end
      cur = {12'b0, bus.out_row_o, bus.out_col_o, bus.out_data_o};
      if (stalled) chk("stall_stable", cur, prev);
      chk("drain_data", 32'(bus.out_data_o), 32'(conv(exp_mem[words])));
      chk("drain_row", 32'(bus.out_row_o), 32'(words / N));
      chk("drain_col", 32'(bus.out_col_o), 32'(words % N));
      got[words] = bus.out_data_o;
      stalled    = !bus.out_ready_i;
      prev       = cur;
      if (bus.out_ready_i) words++;
      tick();
      cyc++;
    end
    bus.out_ready_i = 1'b0;
    chk("handshake_count", 32'(words), 32'(stop_at));
  endtask

  task automatic chk_done();
    chk("done_after_drain", 32'(bus.done_o), 1);
    chk("valid_low_in_done", 32'(bus.out_valid_o), 0);
    chk("busy_low_in_done", 32'(bus.busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RESULT_COLLECTOR_SAT_EN
    tbl[0] = '{acc: 32'h0001_2345, exp: 16'h7fff};
    tbl[1] = '{acc: 32'hfffe_0000, exp: 16'h8000};
`else
    tbl[0] = '{acc: 32'h0001_2345, exp: 16'h2345};
    tbl[1] = '{acc: 32'hfffe_0000, exp: 16'h0000};
`endif
    tbl[2] = '{acc: 32'h0000_7fff, exp: 16'h7fff};
    tbl[3] = '{acc: 32'hffff_8000, exp: 16'h8000};

    bus.acc_valid_i = '0;
    bus.acc_data_i  = '0;
    bus.out_ready_i = 1'b0;

    #12;
    chk("reset_valid", 32'(bus.out_valid_o), 0);
    chk("reset_busy", 32'(bus.busy_o), 0);
    chk("reset_done", 32'(bus.done_o), 0);
    chk("reset_err", 32'(bus.err_o), 0);
    rst_n = 1'b1;
    tick();

    // Basic fill/drain
    set_pattern(0);
    pulse_start();
    chk("busy_in_collect", 32'(bus.busy_o), 1);
    fill(1'b0);
    drain(0, WORDS);
    chk_done();

    // Skewed capture
    pulse_start();
    set_pattern(0);
    fill(1'b1);
    drain(0, WORDS);
    chk_done();

    // Backpressure
    pulse_start();
    set_pattern(32'h1000);
    fill(1'b0);
    drain(1, WORDS);
    chk_done();

    // Overflow: lane 0 strobes a fifth time
    pulse_start();
    set_pattern(32'h200);
    for (int c = 0; c < N; c++) begin
      bus.acc_valid_i           = 4'b0001;
      bus.acc_data_i[0 +: ACC_W] = exp_mem[c];
      tick();
    end
    bus.acc_valid_i            = 4'b0001;
    bus.acc_data_i[0 +: ACC_W] = 32'hdead_beef;
    chk("err_before_overflow", 32'(bus.err_o), 0);
    tick();
    bus.acc_valid_i = '0;
    chk("err_after_overflow", 32'(bus.err_o), 1);
    for (int c = 0; c < N; c++) begin
      bus.acc_valid_i = 4'b1110;
      for (int k = 1; k < N; k++) bus.acc_data_i[k*ACC_W +: ACC_W] = exp_mem[k*N+c];
      tick();
    end
    bus.acc_valid_i = '0;
    chk("drain_after_overflow_fill", 32'(bus.out_valid_o), 1);
    drain(0, WORDS);
    chk_done();
    chk("err_sticky", 32'(bus.err_o), 1);
    pulse_start();
    chk("err_cleared_by_start", 32'(bus.err_o), 0);

    // Protocol error in DONE
    set_pattern(32'h500);
    fill(1'b0);
    drain(0, WORDS);
    chk_done();
    chk("err_clean_drain", 32'(bus.err_o), 0);
    bus.acc_valid_i = 4'b0100;
    tick();
    bus.acc_valid_i = '0;
    chk("err_valid_in_done", 32'(bus.err_o), 1);
    chk("done_holds", 32'(bus.done_o), 1);
    pulse_start();
    chk("err_cleared_again", 32'(bus.err_o), 0);

    // Restart at drain word 5
    set_pattern(32'h300);
    fill(1'b0);
    drain(0, 5);
    chk("word5_row", 32'(bus.out_row_o), 1);
    chk("word5_col", 32'(bus.out_col_o), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_valid_low", 32'(bus.out_valid_o), 0);
    chk("restart_busy", 32'(bus.busy_o), 1);
    chk("restart_not_done", 32'(bus.done_o), 0);
    set_pattern(32'h400);
    fill(1'b0);
    drain(0, WORDS);
    chk_done();

    // Width conversion table
    pulse_start();
    set_pattern(0);
    for (int i = 0; i < 4; i++) exp_mem[i] = tbl[i].acc;
    fill(1'b0);
    drain(0, WORDS);
    chk_done();
    for (int i = 0; i < 4; i++) chk("conv_vector", 32'(got[i]), 32'(tbl[i].exp));

    // Asynchronous reset mid-COLLECT
    pulse_start();
    set_pattern(0);
    bus.acc_valid_i = 4'b1111;
    for (int k = 0; k < N; k++) bus.acc_data_i[k*ACC_W +: ACC_W] = exp_mem[k*N];
    tick();
    bus.acc_valid_i = '0;
    chk("busy_before_reset", 32'(bus.busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(bus.busy_o), 0);
    chk("async_reset_valid", 32'(bus.out_valid_o), 0);
    chk("async_reset_done", 32'(bus.done_o), 0);
    chk("async_reset_err", 32'(bus.err_o), 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(bus.busy_o), 0);
    bus.acc_valid_i = 4'b0001;
    tick();
    bus.acc_valid_i = '0;
    chk("err_valid_in_idle", 32'(bus.err_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Consumer end of the array controller's accumulator-valid interface.
- Captures per-row accumulator results from the N x N systolic array whenever that row's acc_valid strobe is high, and buffers the full N x N result matrix.
- Once the matrix is complete, drains it row-major over a valid/ready stream to the downstream writer.
- Sits between the PE array output and the memory write-back path.

Parameters:
N, 4, array dimension; matrix holds N*N results
ACC_W, 32, accumulator width per lane
OUT_W, 16, output word width (OUT_W <= ACC_W)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  single-cycle pulse; clears buffer state and arms collection
acc_valid_i  input  N  per-row capture strobe, bit k = row k
acc_data_i  input  N*ACC_W  row k accumulator at bits [k*ACC_W +: ACC_W]
out_valid_o  output  1  stream word valid
out_ready_i  input  1  downstream accept
out_data_o  output  OUT_W  result word
out_row_o  output  $clog2(N)  row index of out_data_o
out_col_o  output  $clog2(N)  column index of out_data_o
busy_o  output  1  high in COLLECT or DRAIN
done_o  output  1  high in DONE
err_o  output  1  sticky overflow/protocol error

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all column counters, capture count, read index=0; out_valid_o=0, busy_o=0, done_o=0, err_o=0. Buffer contents are don't-care.
- States:
  - IDLE: start_i -> COLLECT.
  - COLLECT: capture until N*N results are held, then -> DRAIN.
  - DRAIN: stream words; after the last handshake -> DONE.
  - DONE: hold; start_i -> COLLECT.
- start_i in any state, including mid-COLLECT or mid-DRAIN:
  - next state=COLLECT;
  - counters and read index cleared;
  - err_o cleared;
  - acc_valid_i in the same cycle is ignored.
- Capture (COLLECT only):
  - Each lane k has a column counter col[k] (0..N).
  - On acc_valid_i[k]: buf[k][col[k]] <= lane k data; col[k]++.
  - Multiple lanes may capture in the same cycle; the total count is incremented by popcount(acc_valid_i).
  - acc_valid_i[k] with col[k]==N: no write, err_o<=1, counter unchanged.
  - acc_valid_i outside COLLECT: ignored, err_o<=1.
  - When the total reaches N*N (registered), the state becomes DRAIN on that same edge.
- Drain:
  - out_valid_o = (state==DRAIN).
  - Read index rd walks 0..N*N-1; out_row_o=rd/N, out_col_o=rd%N; out_data_o = conv(buf[row][col]).
  - Outputs are combinational from registered rd and buffer; they stay stable while out_valid_o && !out_ready_i.
  - On out_valid_o && out_ready_i: rd++.
  - Handshake at rd==N*N-1 -> DONE on that edge; out_valid_o=0 next cycle.
  - First word is available the cycle after the final capture.
- Width conversion conv(): see Optional Feature. Default is truncation to the low OUT_W bits, with results treated as two's-complement signed.
- busy_o and done_o are decoded from state only.

Optional Feature:
RESULT_COLLECTOR_SAT_EN
- Defined: conv() saturates the signed ACC_W value to the signed OUT_W range. Values above 2^(OUT_W-1)-1 clamp to max; values below -2^(OUT_W-1) clamp to min.
- Undefined: conv() truncates to the low OUT_W bits.
- Neither setting affects control timing.

Test Plan:
- Basic fill/drain:
  - Stimulus: N=4; start; four cycles of all lanes valid, lane k cycle c data = 16*k+c; out_ready_i=1.
  - Required: 16 words, values 0,1,2,3,16,...,51, with row/col matching. First out_valid_o is the cycle after the 4th capture. done_o=1 after word 15.
- Skewed capture:
  - Stimulus: lane k strobes in cycles k..k+3, as the array emits them.
  - Required: same buffer contents as the fill/drain case; DRAIN entered the cycle after lane 3's last capture (capture count 16).
- Backpressure:
  - Stimulus: out_ready_i toggles 1,0,0,1 repeating.
  - Required: out_data_o/out_row_o/out_col_o stable while stalled; no word dropped or duplicated; 16 handshakes total.
- Overflow and protocol error:
  - Stimulus: lane 0 strobes a 5th time in COLLECT.
  - Required: err_o=1 next cycle; buf[0][3] unchanged.
  - Stimulus: acc_valid_i while in DONE.
  - Required: err_o=1.
  - Stimulus: start_i.
  - Required: err_o=0.
- Restart and reset mid-operation:
  - Stimulus: start_i at drain word 5.
  - Required: out_valid_o=0 next cycle; state COLLECT; a fresh fill drains from word 0.
  - Stimulus: rst_ni low asynchronously mid-COLLECT.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
- Width conversion:
  - Stimulus: ACC_W=32, OUT_W=16, data 0x00012345 and 0xFFFE0000.
  - Required, without the macro: 0x2345, 0x0000.
  - Required, with RESULT_COLLECTOR_SAT_EN: 0x7FFF, 0x8000.
